// File: rtl/reg_bank4x16_pkg.sv
// ----------------------------------------------------------------------------
// reg_bank4x16_pkg
//   Shared definitions for the 4x16 register bank and its read multiplexer:
//   default data width, default reset/clear value, the 2-bit entry index
//   type and a one-hot write-decode helper.
// ----------------------------------------------------------------------------
package reg_bank4x16_pkg;

    localparam int unsigned NUM_ENTRIES   = 4;
    localparam int unsigned WIDTH_DEF     = 16;
    localparam logic [15:0] RESET_VAL_DEF = 16'h0000;

    typedef logic [1:0] idx_t;

    // 1-of-4 enable: bit idx set when en is high, all zero otherwise.
    function automatic logic [NUM_ENTRIES-1:0] onehot_dec(input logic en, input idx_t idx);
        logic [NUM_ENTRIES-1:0] res;
        res = '0;
        if (en) begin
            res[idx] = 1'b1;
        end
        return res;
    endfunction

endpackage : reg_bank4x16_pkg

// File: rtl/reg_bank4x16_mux4way16.sv
// ----------------------------------------------------------------------------
// mux4way16
//   Combinational 4-way word multiplexer.
//   Ports:
//     a, b, c, d : in  WIDTH  data inputs (selected by sel = 0,1,2,3)
//     sel        : in  2      select
//     out        : out WIDTH  selected word
// ----------------------------------------------------------------------------
module mux4way16
    import reg_bank4x16_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  idx_t             sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = a;
        unique case (sel)
            2'd0: out = a;
            2'd1: out = b;
            2'd2: out = c;
            2'd3: out = d;
            default: out = a;
        endcase
    end

endmodule : mux4way16

// File: rtl/reg_bank4x16.sv
// ----------------------------------------------------------------------------
// reg_bank4x16
//   Four-entry register bank with per-entry valid bits, a direct view of every
//   entry (q0..q3, feeding mux4way16 downstream) and a one-cycle registered
//   read port.
//   Ports:
//     clk    : in  1      clock, all updates on posedge
//     rst_n  : in  1      asynchronous active-low reset
//     clr    : in  1      synchronous clear (entries <= RESET_VAL, valid <= 0)
//     we     : in  1      write enable
//     waddr  : in  2      write index
//     wdata  : in  WIDTH  write data
//     re     : in  1      read request
//     raddr  : in  2      read index
//     rdata  : out WIDTH  registered read data (holds when no read)
//     rvalid : out 1      one-cycle pulse the cycle after re
//     q0..q3 : out WIDTH  unregistered view of each entry
//     valid  : out 4      entry written since last reset/clear
// ----------------------------------------------------------------------------
module reg_bank4x16
    import reg_bank4x16_pkg::*;
#(
    parameter int unsigned      WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   we,
    input  idx_t                   waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   re,
    input  idx_t                   raddr,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    output logic [WIDTH-1:0]       q0,
    output logic [WIDTH-1:0]       q1,
    output logic [WIDTH-1:0]       q2,
    output logic [WIDTH-1:0]       q3,
    output logic [NUM_ENTRIES-1:0] valid
);

    logic [WIDTH-1:0]       entry_q [NUM_ENTRIES];
    logic [WIDTH-1:0]       entry_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] valid_d;
    logic [WIDTH-1:0]       rdata_q;
    logic [WIDTH-1:0]       rdata_d;
    logic                   rvalid_q;
    logic                   rvalid_d;

    logic [NUM_ENTRIES-1:0] wr_en;
    logic [WIDTH-1:0]       mux_out;
    logic [WIDTH-1:0]       rd_word;

    assign wr_en = onehot_dec(we, waddr);

    // ---------------- entry storage ----------------
    // clr overrides any write in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            entry_d[i] = entry_q[i];
            if (clr) begin
                entry_d[i] = RESET_VAL;
            end else if (wr_en[i]) begin
                entry_d[i] = wdata;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d = '0;
        end else begin
            valid_d = valid_q | wr_en;
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_q[g] <= RESET_VAL;
            end else begin
                entry_q[g] <= entry_d[g];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // ---------------- read port ----------------
    mux4way16 #(
        .WIDTH (WIDTH)
    ) u_rd_mux (
        .a   (entry_q[0]),
        .b   (entry_q[1]),
        .c   (entry_q[2]),
        .d   (entry_q[3]),
        .sel (raddr),
        .out (mux_out)
    );

    // Bypass gives the read the same post-clear/post-write value the entry
    // is about to take, so a same-cycle read is write-first.
    always_comb begin
        rd_word = mux_out;
        if (clr) begin
            rd_word = RESET_VAL;
        end else if (we && (waddr == raddr)) begin
            rd_word = wdata;
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re;
        if (re) begin
            rdata_d = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // ---------------- outputs ----------------
    assign q0     = entry_q[0];
    assign q1     = entry_q[1];
    assign q2     = entry_q[2];
    assign q3     = entry_q[3];
    assign valid  = valid_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule : reg_bank4x16
